// File: rtl/led_arb_pkg.sv
// Shared types for the LED share arbiter.
// State encoding and one-hot grant codes.
package led_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GNT_A,
    S_GNT_B
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

  // One-hot grant code for a state
  function automatic logic [1:0] gnt_of(arb_state_t s);
    logic [1:0] g;
    g = GNT_NONE;
    unique case (1'b1)
      (s == S_GNT_A): g = GNT_A;
      (s == S_GNT_B): g = GNT_B;
      default:        g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/led_arb_hold_cnt.sv
// Saturating hold counter for the arbiter's timeout.
// Cleared on grant entry, counts up to MAX_HOLD-1.
module led_arb_hold_cnt #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic clk_2,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic at_max
);

  localparam int unsigned W =
    (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [W-1:0] LIM = W'(MAX_HOLD - 1);

  logic [W-1:0] cnt;

  // Count granted cycles, saturating at the limit
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == LIM);

endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin share of one LED field between requesters A and B.
// ARB_TIMEOUT_EN: preempt a contested owner after MAX_HOLD cycles.
module led_share_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned NBITS_DATA = 2,
  parameter int unsigned MAX_HOLD   = 4,
  parameter int unsigned NBITS_SW   = 8
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic [NBITS_DATA-1:0] data_a,
  input  logic [NBITS_DATA-1:0] data_b,
  output logic [1:0]            gnt,
  output logic [NBITS_DATA-1:0] led_out,
  output logic                  busy,
  output logic [NBITS_SW-1:0]   switch_cnt
);

  arb_state_t state;
  arb_state_t nxt;
  logic       last_b;
  logic       at_max;
  logic       swap;

`ifdef ARB_TIMEOUT_EN
  led_arb_hold_cnt #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold (
    .clk_2 (clk_2),
    .reset (reset),
    .clr   (nxt != state),
    .en    (state != S_IDLE),
    .at_max(at_max)
  );
`else
  // MAX_HOLD is at least 1, so the hold never expires here
  assign at_max = (MAX_HOLD < 1);
`endif

  // Next owner: tie goes to the side not served last
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (req_a && req_b) begin
          nxt = last_b ? S_GNT_A : S_GNT_B;
        end else if (req_a) begin
          nxt = S_GNT_A;
        end else if (req_b) begin
          nxt = S_GNT_B;
        end
      end
      S_GNT_A: begin
        if (req_b && (!req_a || at_max)) begin
          nxt = S_GNT_B;
        end else if (!req_a) begin
          nxt = S_IDLE;
        end
      end
      S_GNT_B: begin
        if (req_a && (!req_b || at_max)) begin
          nxt = S_GNT_A;
        end else if (!req_b) begin
          nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign swap = (state != S_IDLE) && (nxt != S_IDLE) &&
                (nxt != state);

  // State, registered outputs, last owner and handoff count
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      gnt        <= GNT_NONE;
      led_out    <= '0;
      busy       <= 1'b0;
      switch_cnt <= '0;
      last_b     <= 1'b1;
    end else begin
      state <= nxt;
      gnt   <= gnt_of(nxt);
      busy  <= (nxt != S_IDLE);
      if (nxt == S_GNT_A) begin
        led_out <= data_a;
      end else if (nxt == S_GNT_B) begin
        led_out <= data_b;
      end else begin
        led_out <= '0;
      end
      if ((nxt != S_IDLE) && (nxt != state)) begin
        last_b <= (nxt == S_GNT_B);
      end
      if (swap) begin
        switch_cnt <= switch_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_share_arbiter.sv
// Scoreboard bench for led_share_arbiter.
// Reference model tracks owner, hold length and handoff count.
module tb_led_share_arbiter;

  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  typedef struct {
    logic [1:0] gnt;
    logic [1:0] led;
    logic       busy;
    logic [7:0] cnt;
  } exp_t;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic [1:0] data_a = '0;
  logic [1:0] data_b = '0;
  logic [1:0] gnt;
  logic [1:0] led_out;
  logic       busy;
  logic [7:0] switch_cnt;

  int checks = 0;
  int errors = 0;

  exp_t q[$];

  // model: owner 0=none 1=A 2=B; held = granted cycles so far
  int m_owner = 0;
  int m_last  = 2;
  int m_held  = 0;
  int m_cnt   = 0;

  led_share_arbiter #(
    .NBITS_DATA(2),
    .MAX_HOLD  (MAX_HOLD),
    .NBITS_SW  (8)
  ) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .req_a     (req_a),
    .req_b     (req_b),
    .data_a    (data_a),
    .data_b    (data_b),
    .gnt       (gnt),
    .led_out   (led_out),
    .busy      (busy),
    .switch_cnt(switch_cnt)
  );

  always #5 clk_2 = ~clk_2;

  function automatic void model_reset();
    m_owner = 0;
    m_last  = 2;
    m_held  = 0;
    m_cnt   = 0;
  endfunction

  function automatic void model_step(bit ra, bit rb,
                                     int da, int db);
    exp_t e;
    bit mine, other, expire;
    int prev;
    prev = m_owner;
    if (m_owner == 0) begin
      if (ra && rb) m_owner = (m_last == 1) ? 2 : 1;
      else if (ra) m_owner = 1;
      else if (rb) m_owner = 2;
    end else begin
      mine   = (m_owner == 1) ? ra : rb;
      other  = (m_owner == 1) ? rb : ra;
      expire = TIMEOUT && other && (m_held >= MAX_HOLD);
      if (other && (!mine || expire)) begin
        m_owner = 3 - m_owner;
        m_cnt   = (m_cnt + 1) % 256;
      end else if (!mine) begin
        m_owner = 0;
      end
    end
    if (m_owner != 0 && m_owner != prev) begin
      m_held = 1;
      m_last = m_owner;
    end else if (m_owner != 0) begin
      m_held = m_held + 1;
    end
    e.gnt  = (m_owner == 1) ? 2'b01 :
             (m_owner == 2) ? 2'b10 : 2'b00;
    e.led  = (m_owner == 1) ? 2'(da) :
             (m_owner == 2) ? 2'(db) : 2'b00;
    e.busy = (m_owner != 0);
    e.cnt  = 8'(m_cnt);
    q.push_back(e);
  endfunction

  task automatic apply(bit ra, bit rb, int da, int db);
    req_a  = ra;
    req_b  = rb;
    data_a = 2'(da);
    data_b = 2'(db);
    model_step(ra, rb, da, db);
  endtask

  task automatic cyc(bit ra, bit rb, int da, int db);
    @(negedge clk_2);
    apply(ra, rb, da, db);
  endtask

  task automatic check_zero(string name);
    checks++;
    if (gnt !== 2'b00 || led_out !== 2'b00 ||
        busy !== 1'b0 || switch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL %s: gnt=%b led=%b busy=%b cnt=%0d want all 0",
               name, gnt, led_out, busy, switch_cnt);
    end
  endtask

  // asynchronous reset between clock edges
  task automatic async_reset(string name);
    @(posedge clk_2);
    #3;
    reset = 1'b1;
    #1;
    check_zero(name);
    model_reset();
    @(negedge clk_2);
    reset = 1'b0;
    apply(0, 0, 0, 0);
  endtask

  // monitor: compare every registered output after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_2);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (gnt !== e.gnt || led_out !== e.led ||
            busy !== e.busy || switch_cnt !== e.cnt) begin
          errors++;
          $display("FAIL cycle @%0t: got gnt=%b led=%b busy=%b cnt=%0d want gnt=%b led=%b busy=%b cnt=%0d",
                   $time, gnt, led_out, busy, switch_cnt,
                   e.gnt, e.led, e.busy, e.cnt);
        end
        if (gnt === 2'b11) begin
          errors++;
          $display("FAIL gnt_onehot: got 11 want not 11");
        end
      end
    end
  end

  initial begin
    int ra, rb, wait_cyc;
    // power-on reset
    @(negedge clk_2);
    check_zero("reset_state");
    model_reset();
    reset = 1'b0;
    apply(0, 0, 0, 0);

    // single requester, data follows
    cyc(1, 0, 2, 3);
    cyc(1, 0, 1, 3);
    cyc(0, 0, 1, 3);

    // tie after reset goes to A, then direct handoff
    async_reset("reset_tie");
    cyc(1, 1, 1, 2);
    cyc(0, 1, 1, 2);
    cyc(0, 1, 3, 0);

    // B releases to idle, A then granted
    cyc(0, 0, 3, 0);
    cyc(1, 0, 2, 1);
    cyc(0, 0, 2, 1);

    // both held: timeout rotation or fixed owner
    async_reset("reset_contend");
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, $urandom_range(3), $urandom_range(3));
    end

    // reset mid-grant, then tie goes to A again
    async_reset("reset_midgrant");
    cyc(1, 1, 2, 1);
    cyc(1, 1, 3, 1);

    // forced handoffs through switch_cnt wrap
    async_reset("reset_wrap");
    for (int i = 0; i < 262; i++) begin
      cyc(i % 2 == 0, i % 2 == 1,
          $urandom_range(3), $urandom_range(3));
    end

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        async_reset("reset_random");
      end
      ra = ($urandom_range(9) < 6) ? 1 : 0;
      rb = ($urandom_range(9) < 5) ? 1 : 0;
      cyc(ra[0], rb[0], $urandom_range(3), $urandom_range(3));
    end
    cyc(0, 0, 0, 0);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk_2);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
